pomodoro_sequencer: RTL
=======================

# pomodoro_sequencer

Session scheduler for the Pomodoro timer. It sequences work, short-break and long-break phases and owns the mm:ss countdown registers. It sits between the debounced button pulses and the 7-segment shift-register display driver (sclk/rclk/dio), which consumes its BCD outputs. All time advances on a one-cycle 1 Hz strobe from the prescaler, so the block is clock-frequency agnostic.

## Interface
- WORK_MIN, 25, work phase length in minutes (1..99)
- SHORT_MIN, 5, short break length in minutes (1..99)
- LONG_MIN, 15, long break length in minutes (1..99)
- SESSIONS_PER_LONG, 4, completed work phases before a long break (1..7)

- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  synchronous, active-low reset
- tick  in  1  1 Hz strobe, high for one cycle
- start_p  in  1  start/resume pulse (debounced, one cycle)
- pause_p  in  1  pause pulse
- skip_p  in  1  skip-phase pulse
- clear_p  in  1  clear pulse: return to the initial state
- min_bcd  out  8  minutes as two BCD digits
- sec_bcd  out  8  seconds as two BCD digits
- phase  out  2  0=WORK, 1=SHORT, 2=LONG
- running  out  1  high in RUN
- alert  out  1  high in ALERT
- alarm  out  1  one-cycle pulse on phase expiry
- session_cnt  out  3  completed work phases since the last long break

## Operation
- FSM states: IDLE, RUN, PAUSED, ALERT.
- Reset (rst=0 at an edge) produces:
  - state IDLE, phase WORK, min_bcd=WORK_MIN in BCD, sec_bcd=0x00;
  - session_cnt=0, running=0, alert=0, alarm=0.
- Command priority within a cycle: clear_p > skip_p > start_p/pause_p > tick.
- IDLE:
  - start_p → RUN.
  - tick is ignored.
- RUN:
  - tick decrements mm:ss in BCD.
  - When sec=00, sec becomes 59 and min is decremented.
  - Units digit 0 borrows from tens: 0x40 → 0x39.
  - pause_p → PAUSED.
- PAUSED:
  - tick is ignored.
  - start_p or pause_p → RUN.
- Expiry: a tick in RUN with value 00:01 performs all of the following in one edge:
  - alarm=1 for one cycle; state → ALERT;
  - next phase is selected and its duration loaded (mm:00).
- Next-phase rule:
  - WORK expiring increments session_cnt.
  - If the incremented count equals SESSIONS_PER_LONG, the next phase is LONG; otherwise SHORT.
  - SHORT or LONG expiring → WORK.
  - Entering LONG clears session_cnt to 0.
- ALERT:
  - start_p → RUN in the new phase.
  - tick is ignored; the display holds the full new duration.
- skip_p, in any state other than IDLE:
  - advance phase using the next-phase rule, but session_cnt is not incremented;
  - load duration; state → IDLE; no alarm.
- skip_p in IDLE also advances the phase.
- clear_p in any state is equivalent to reset.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- A countdown change is visible on the first edge after the tick cycle.
- alarm is asserted on the edge after the expiring tick and deasserts one cycle later.
- start_p and tick in the same cycle in IDLE: transition to RUN only. The first decrement happens on the next tick.
- pause_p and tick in the same cycle in RUN: pause wins, no decrement.
- clear_p or skip_p coincident with the expiring tick: clear/skip wins and alarm stays 0.
- Value 00:00 is never displayed; expiry reloads directly.

## Configuration
- LONG_BREAK_EN, when defined:
  - long breaks are scheduled per SESSIONS_PER_LONG;
  - session_cnt counts 0..SESSIONS_PER_LONG-1.
- LONG_BREAK_EN, when undefined:
  - every WORK phase is followed by SHORT; phase never equals 2;
  - LONG_MIN is unused and session_cnt is held at 0.

## Test plan
Parameters: WORK_MIN=1, SHORT_MIN=1, LONG_MIN=2, SESSIONS_PER_LONG=2, LONG_BREAK_EN defined.
- Reset, then start_p, then 1 tick → min_bcd=0x00, sec_bcd=0x59, running=1, phase=0.
- From RUN at 01:00, 60 ticks → exactly one alarm pulse, alert=1, phase=1, display 01:00, session_cnt=1.
- Two full work cycles with the intervening short break → second WORK expiry gives phase=2, display 02:00, session_cnt=0.
- Mid-count pause_p, 5 ticks, start_p, 1 tick → value decremented by exactly 1 s across the pause.
- skip_p in RUN at 00:30 of WORK → phase=1, 01:00, IDLE, alarm=0, session_cnt unchanged. Also drive clear_p coincident with the expiring tick → initial state and no alarm.
- Rebuild without LONG_BREAK_EN and repeat the long-break scenario → phase=1, session_cnt=0 throughout.

Source files
------------

// File: rtl/pomodoro_sequencer_if.sv
// pomodoro_sequencer_if: button/tick commands in, BCD countdown and phase status out
interface pomodoro_sequencer_if;
  logic       tick;
  logic       start_p;
  logic       pause_p;
  logic       skip_p;
  logic       clear_p;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic [1:0] phase;
  logic       running;
  logic       alert;
  logic       alarm;
  logic [2:0] session_cnt;
  modport slave (
    input  tick, start_p, pause_p, skip_p, clear_p,
    output min_bcd, sec_bcd, phase, running, alert, alarm, session_cnt
  );
  modport master (
    output tick, start_p, pause_p, skip_p, clear_p,
    input  min_bcd, sec_bcd, phase, running, alert, alarm, session_cnt
  );
endinterface

// File: rtl/pomodoro_sequencer.sv
// pomodoro_sequencer: work/short/long phase scheduler owning the BCD mm:ss countdown
// Define LONG_BREAK_EN to schedule long breaks every SESSIONS_PER_LONG work phases.
module pomodoro_sequencer #(
  parameter int WORK_MIN          = 25,
  parameter int SHORT_MIN         = 5,
  parameter int LONG_MIN          = 15,
  parameter int SESSIONS_PER_LONG = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  pomodoro_sequencer_if.slave     bus
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, ALERT} state_t;
  localparam logic [1:0] WORK  = 2'd0;
  localparam logic [1:0] SHORT = 2'd1;
  localparam logic [1:0] LONG  = 2'd2;
`ifdef LONG_BREAK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif
  function automatic logic [7:0] to_bcd(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction
  localparam logic [7:0] WORK_BCD  = to_bcd(WORK_MIN);
  localparam logic [7:0] SHORT_BCD = to_bcd(SHORT_MIN);
  localparam logic [7:0] LONG_BCD  = to_bcd(LONG_MIN);
  function automatic logic [7:0] dec_bcd(logic [7:0] v);
    return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
  endfunction
  function automatic logic [7:0] dur(logic [1:0] ph);
    return (ph == LONG) ? LONG_BCD : (ph == SHORT) ? SHORT_BCD : WORK_BCD;
  endfunction
  // {next phase, next session count}; a skip advances without crediting the work phase
  function automatic logic [4:0] advance(logic [1:0] ph, logic [2:0] cnt, logic inc);
    logic [2:0] c;
    c = cnt + 3'(inc);
    if (ph != WORK) return {WORK, cnt};
    if (LB && c == 3'(SESSIONS_PER_LONG)) return {LONG, 3'd0};
    return {SHORT, LB ? c : 3'd0};
  endfunction
  state_t     state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic       alarm_q, alarm_d;
  logic [4:0] adv_skip, adv_exp;
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    min_d    = min_q;
    sec_d    = sec_q;
    alarm_d  = 1'b0;
    adv_skip = advance(phase_q, cnt_q, 1'b0);
    adv_exp  = advance(phase_q, cnt_q, 1'b1);
    if (bus.clear_p) begin
      state_d = IDLE;
      phase_d = WORK;
      cnt_d   = 3'd0;
      min_d   = WORK_BCD;
      sec_d   = 8'h00;
    end else if (bus.skip_p) begin
      state_d          = IDLE;
      {phase_d, cnt_d} = adv_skip;
      min_d            = dur(adv_skip[4:3]);
      sec_d            = 8'h00;
    end else begin
      case (state_q)
        IDLE:   state_d = bus.start_p ? RUN : IDLE;
        RUN: begin
          if (bus.pause_p) state_d = PAUSED;
          else if (bus.tick) begin
            // 00:01 reloads the next phase directly so 00:00 is never shown
            if (min_q == 8'h00 && sec_q == 8'h01) begin
              state_d          = ALERT;
              alarm_d          = 1'b1;
              {phase_d, cnt_d} = adv_exp;
              min_d            = dur(adv_exp[4:3]);
              sec_d            = 8'h00;
            end else begin
              sec_d = (sec_q == 8'h00) ? 8'h59 : dec_bcd(sec_q);
              min_d = (sec_q == 8'h00) ? dec_bcd(min_q) : min_q;
            end
          end
        end
        PAUSED: state_d = (bus.start_p || bus.pause_p) ? RUN : PAUSED;
        ALERT:  state_d = bus.start_p ? RUN : ALERT;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      phase_q <= WORK;
      cnt_q   <= 3'd0;
      min_q   <= WORK_BCD;
      sec_q   <= 8'h00;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      alarm_q <= alarm_d;
    end
  end
  assign bus.min_bcd     = min_q;
  assign bus.sec_bcd     = sec_q;
  assign bus.phase       = phase_q;
  assign bus.running     = (state_q == RUN);
  assign bus.alert       = (state_q == ALERT);
  assign bus.alarm       = alarm_q;
  assign bus.session_cnt = cnt_q;
endmodule
